// File: rtl/mor1kx_dbg_gpr_access_if.sv
// Signal bundle between the debug command front-end, the GPR access
// sequencer and the core's SPR bus. Signal names keep their _i/_o suffixes
// as seen from the sequencer, which uses the slave modport; the front-end
// and SPR responder side of the system uses the master modport.
interface mor1kx_dbg_gpr_access_if #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_GPR_IDX_WIDTH = 5
);
  logic                            dbg_req_valid_i;
  logic                            dbg_req_ready_o;
  logic                            dbg_req_we_i;
  logic [OPTION_GPR_IDX_WIDTH-1:0] dbg_req_gpr_i;
  logic [7:0]                      dbg_req_len_i;

  logic                            dbg_wdat_valid_i;
  logic                            dbg_wdat_ready_o;
  logic [OPTION_OPERAND_WIDTH-1:0] dbg_wdat_i;

  logic                            dbg_rdat_valid_o;
  logic                            dbg_rdat_ready_i;
  logic [OPTION_OPERAND_WIDTH-1:0] dbg_rdat_o;

  logic                            dbg_done_o;
  logic                            dbg_err_o;

  logic [15:0]                     spr_bus_addr_o;
  logic                            spr_bus_stb_o;
  logic                            spr_bus_we_o;
  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_o;
  logic                            spr_gpr_ack_i;
  logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_i;

  modport slave (
    input  dbg_req_valid_i, dbg_req_we_i, dbg_req_gpr_i, dbg_req_len_i,
    output dbg_req_ready_o,
    input  dbg_wdat_valid_i, dbg_wdat_i,
    output dbg_wdat_ready_o,
    output dbg_rdat_valid_o, dbg_rdat_o,
    input  dbg_rdat_ready_i,
    output dbg_done_o, dbg_err_o,
    output spr_bus_addr_o, spr_bus_stb_o, spr_bus_we_o, spr_bus_dat_o,
    input  spr_gpr_ack_i, spr_gpr_dat_i
  );

  modport master (
    output dbg_req_valid_i, dbg_req_we_i, dbg_req_gpr_i, dbg_req_len_i,
    input  dbg_req_ready_o,
    output dbg_wdat_valid_i, dbg_wdat_i,
    input  dbg_wdat_ready_o,
    input  dbg_rdat_valid_o, dbg_rdat_o,
    output dbg_rdat_ready_i,
    input  dbg_done_o, dbg_err_o,
    input  spr_bus_addr_o, spr_bus_stb_o, spr_bus_we_o, spr_bus_dat_o,
    output spr_gpr_ack_i, spr_gpr_dat_i
  );
endinterface

// File: rtl/mor1kx_dbg_gpr_access.sv
// Debug-side SPR bus initiator for the GPR window (0x0400-0x05FF).
// Turns single/burst GPR read or write requests into SPR transactions with
// stb held until ack and at least one stb-low cycle between accesses.
// Optional ack timeout: define MOR1KX_DBG_GPR_TIMEOUT_EN to build the
// stb-high cycle counter and the burst abort path; without it the bus
// waits for ack indefinitely and dbg_err_o is constant 0.
// The interface instance must carry the same width parameters as this module.
module mor1kx_dbg_gpr_access #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_GPR_IDX_WIDTH = 5,
  parameter int TIMEOUT_CYCLES       = 255
) (
  input logic                    clk,
  input logic                    rst_n,
  mor1kx_dbg_gpr_access_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WDAT   = 3'd1,
    ACCESS = 3'd2,
    RDATA  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic                            we_q;
  logic [OPTION_GPR_IDX_WIDTH-1:0] idx_q;
  logic [7:0]                      cnt_q;
  logic [OPTION_OPERAND_WIDTH-1:0] wdat_q;
  logic [OPTION_OPERAND_WIDTH-1:0] rdat_q;

  logic take_req;
  logic take_wdat;
  logic cap_rdat;
  logic beat_adv;
  logic tmo_expire;

  // State register; reset drops stb immediately since stb decodes the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake decode; ack wins over a coincident timeout.
  always_comb begin
    state_d   = state_q;
    take_req  = 1'b0;
    take_wdat = 1'b0;
    cap_rdat  = 1'b0;
    beat_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dbg_req_valid_i) begin
          take_req = 1'b1;
          state_d  = bus.dbg_req_we_i ? WDAT : ACCESS;
        end
      end
      WDAT: begin
        if (bus.dbg_wdat_valid_i) begin
          take_wdat = 1'b1;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.spr_gpr_ack_i) begin
          if (!we_q) begin
            cap_rdat = 1'b1;
            state_d  = RDATA;
          end else if (cnt_q != 8'd0) begin
            beat_adv = 1'b1;
            state_d  = WDAT;
          end else begin
            state_d  = DONE;
          end
        end else if (tmo_expire) begin
          state_d = DONE;
        end
      end
      RDATA: begin
        if (bus.dbg_rdat_ready_i) begin
          if (cnt_q != 8'd0) begin
            beat_adv = 1'b1;
            state_d  = ACCESS;
          end else begin
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst control: direction, wrapping GPR index, non-wrapping beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q  <= 1'b0;
      idx_q <= '0;
      cnt_q <= 8'd0;
    end else if (take_req) begin
      we_q  <= bus.dbg_req_we_i;
      idx_q <= bus.dbg_req_gpr_i;
      cnt_q <= bus.dbg_req_len_i;
    end else if (beat_adv) begin
      idx_q <= idx_q + 1'b1;
      cnt_q <= cnt_q - 8'd1;
    end
  end

  // Data holding registers; outputs are gated by state, so no reset needed.
  always_ff @(posedge clk) begin
    if (take_wdat) wdat_q <= bus.dbg_wdat_i;
    if (cap_rdat)  rdat_q <= bus.spr_gpr_dat_i;
  end

`ifdef MOR1KX_DBG_GPR_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt_q;
  logic        err_q;

  // Count stb-high cycles; restarts each time ACCESS is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 tmo_cnt_q <= 16'd0;
    else if (state_q != ACCESS) tmo_cnt_q <= 16'd0;
    else                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
  end

  assign tmo_expire = (state_q == ACCESS) && (tmo_cnt_q == TMO_LAST);

  // Error flag reflects how the last ACCESS cycle ended; held through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 err_q <= 1'b0;
    else if (state_q == ACCESS) err_q <= tmo_expire && !bus.spr_gpr_ack_i;
  end

  assign bus.dbg_err_o = (state_q == DONE) && err_q;
`else
  // The limit has no effect in this build; referenced only so both builds
  // share one parameter list.
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_unused
  end
  assign tmo_expire    = 1'b0;
  assign bus.dbg_err_o = 1'b0;
`endif

  assign bus.dbg_req_ready_o  = (state_q == IDLE);
  assign bus.dbg_wdat_ready_o = (state_q == WDAT);
  assign bus.dbg_rdat_valid_o = (state_q == RDATA);
  assign bus.dbg_rdat_o       = (state_q == RDATA) ? rdat_q : '0;
  assign bus.dbg_done_o       = (state_q == DONE);

  assign bus.spr_bus_stb_o  = (state_q == ACCESS);
  assign bus.spr_bus_we_o   = (state_q == ACCESS) && we_q;
  assign bus.spr_bus_addr_o = (state_q == ACCESS)
                              ? (16'h0400 | {{(16-OPTION_GPR_IDX_WIDTH){1'b0}}, idx_q})
                              : 16'h0000;
  assign bus.spr_bus_dat_o  = ((state_q == ACCESS) && we_q) ? wdat_q : '0;

endmodule

// File: tb/tb_mor1kx_dbg_gpr_access.sv
// Randomized bench for mor1kx_dbg_gpr_access: a behavioural SPR responder
// with its own register file, and a transaction-level model that predicts
// the address/data sequence of each burst and the read data returned.
`timescale 1ns/1ps
module tb_mor1kx_dbg_gpr_access;
  localparam int DW     = 32;
  localparam int IW     = 5;
  localparam int NGPR   = 1 << IW;
  localparam int BUDGET = 5000;
`ifdef MOR1KX_DBG_GPR_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mor1kx_dbg_gpr_access_if #(.OPTION_OPERAND_WIDTH(DW), .OPTION_GPR_IDX_WIDTH(IW)) bus ();

  mor1kx_dbg_gpr_access #(
    .OPTION_OPERAND_WIDTH(DW),
    .OPTION_GPR_IDX_WIDTH(IW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Responder register file, bench-side reference copy, write data buffer
  logic [DW-1:0] rf   [NGPR];
  logic [DW-1:0] gold [NGPR];
  logic [DW-1:0] wbuf [256];

  // Responder controls and observations
  int  ack_cyc   = 1;
  bit  ack_never = 1'b0;
  int  stb_run   = 0;
  int  stb_rises = 0;
  int  stb_max   = 0;
  int  stab_err  = 0;
  logic [15:0]   acc_addr_q [$];
  bit            acc_we_q   [$];
  logic [DW-1:0] acc_dat_q  [$];
  logic [15:0]   hold_addr;
  logic          hold_we;
  logic [DW-1:0] hold_dat;

  // SPR responder: acks after ack_cyc+1 stb-high cycles, checks stability
  initial begin
    bus.spr_gpr_ack_i = 1'b0;
    bus.spr_gpr_dat_i = '0;
    forever begin
      @(negedge clk);
      bus.spr_gpr_ack_i = 1'b0;
      bus.spr_gpr_dat_i = $urandom;
      if (bus.spr_bus_stb_o) begin
        stb_run++;
        if (stb_run == 1) begin
          stb_rises++;
          hold_addr = bus.spr_bus_addr_o;
          hold_we   = bus.spr_bus_we_o;
          hold_dat  = bus.spr_bus_dat_o;
        end else if (bus.spr_bus_addr_o !== hold_addr || bus.spr_bus_we_o !== hold_we ||
                     bus.spr_bus_dat_o !== hold_dat) begin
          stab_err++;
        end
        if (stb_run > stb_max) stb_max = stb_run;
        if (!ack_never && stb_run == ack_cyc + 1) begin
          bus.spr_gpr_ack_i = 1'b1;
          acc_addr_q.push_back(bus.spr_bus_addr_o);
          acc_we_q.push_back(bus.spr_bus_we_o);
          if (bus.spr_bus_we_o) begin
            rf[bus.spr_bus_addr_o[IW-1:0]] = bus.spr_bus_dat_o;
            acc_dat_q.push_back(bus.spr_bus_dat_o);
          end else begin
            bus.spr_gpr_dat_i = rf[bus.spr_bus_addr_o[IW-1:0]];
            acc_dat_q.push_back(rf[bus.spr_bus_addr_o[IW-1:0]]);
          end
        end
      end else begin
        stb_run = 0;
      end
    end
  end

  // One debug transaction; wbuf holds write data. rst_beat>0 pulses reset
  // while the stb of that beat is high.
  task automatic run_txn(input bit we, input int gpr, input int len, input int stall_pct,
                         input int hold, input int rst_beat, input bit exp_to);
    int beats;
    int idx_e [256];
    logic [DW-1:0] dat_e [256];
    int wi, ri, cyc, hold_left, exp_acc;
    bit got_done, hs_w, hs_r, prev_rv, reset_done;
    logic [DW-1:0] prev_rd;
    beats = len + 1;
    for (int k = 0; k < beats; k++) begin
      idx_e[k] = (gpr + k) % NGPR;
      dat_e[k] = we ? wbuf[k] : gold[idx_e[k]];
    end
    acc_addr_q.delete(); acc_we_q.delete(); acc_dat_q.delete();
    stb_rises = 0; stb_max = 0; stab_err = 0;
    wi = 0; ri = 0; cyc = 0; hold_left = hold;
    got_done = 1'b0; prev_rv = 1'b0; prev_rd = '0; reset_done = 1'b0;

    bus.dbg_req_valid_i = 1'b1;
    bus.dbg_req_we_i    = we;
    bus.dbg_req_gpr_i   = gpr[IW-1:0];
    bus.dbg_req_len_i   = len[7:0];
    while (!bus.dbg_req_ready_o && cyc < BUDGET) begin
      @(posedge clk); #1; cyc++;
    end
    chk("req_ready", bus.dbg_req_ready_o, 1'b1);
    @(posedge clk); #1;
    bus.dbg_req_valid_i = 1'b0;
    if (!we) chk("rd_stb_latency", bus.spr_bus_stb_o, 1'b1);

    while (!got_done && !reset_done && cyc < BUDGET) begin
      if (bus.spr_gpr_ack_i && !we) begin
        chk("ack_to_rvalid", bus.dbg_rdat_valid_o, 1'b1);
        chk("ack_to_stb_low", bus.spr_bus_stb_o, 1'b0);
      end
      if (bus.dbg_done_o) begin
        got_done = 1'b1;
      end else if (rst_beat > 0 && stb_rises == rst_beat && bus.spr_bus_stb_o) begin
        rst_n = 1'b0;
        #1;
        chk("rst_stb_drop", bus.spr_bus_stb_o, 1'b0);
        bus.dbg_wdat_valid_i = 1'b0;
        bus.dbg_rdat_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("rst_ready", bus.dbg_req_ready_o, 1'b1);
        reset_done = 1'b1;
      end else begin
        bus.dbg_wdat_valid_i = we && (wi < beats) && ($urandom_range(0, 99) >= stall_pct);
        bus.dbg_wdat_i       = (wi < beats) ? wbuf[wi] : DW'($urandom);
        if (hold_left > 0) begin
          bus.dbg_rdat_ready_i = 1'b0;
          if (bus.dbg_rdat_valid_o) hold_left--;
        end else begin
          bus.dbg_rdat_ready_i = ($urandom_range(0, 99) >= stall_pct);
        end
        hs_w = bus.dbg_wdat_valid_i && bus.dbg_wdat_ready_o;
        hs_r = bus.dbg_rdat_valid_o && bus.dbg_rdat_ready_i;
        if (prev_rv) begin
          chk("rvalid_hold", bus.dbg_rdat_valid_o, 1'b1);
          chk("rdat_hold", bus.dbg_rdat_o, prev_rd);
        end
        if (bus.dbg_rdat_valid_o) begin
          chk("rvalid_stb_low", bus.spr_bus_stb_o, 1'b0);
          if (hs_r) begin
            chk("rdat", bus.dbg_rdat_o, (ri < beats) ? dat_e[ri] : '0);
            ri++;
          end
        end
        prev_rv = bus.dbg_rdat_valid_o && !hs_r;
        prev_rd = bus.dbg_rdat_o;
        @(posedge clk); #1; cyc++;
        if (hs_w) wi++;
      end
    end
    bus.dbg_wdat_valid_i = 1'b0;
    bus.dbg_rdat_ready_i = 1'b0;

    if (rst_beat == 0) begin
      chk("done_seen", got_done, 1'b1);
      chk("err", bus.dbg_err_o, exp_to);
      @(posedge clk); #1;
      chk("done_one_cycle", bus.dbg_done_o, 1'b0);
      chk("ready_after_done", bus.dbg_req_ready_o, 1'b1);
      chk("rdat_beats", ri, (we || exp_to) ? 0 : beats);
      chk("wdat_beats", wi, we ? (exp_to ? 1 : beats) : 0);
      chk("stb_accesses", stb_rises, exp_to ? 1 : beats);
      if (exp_to) chk("stb_high_cycles", stb_max, TMO);
      exp_acc = exp_to ? 0 : beats;
    end else begin
      for (int k = 0; k < 3; k++) begin
        chk("no_done_after_rst", bus.dbg_done_o, 1'b0);
        @(posedge clk); #1;
      end
      exp_acc = rst_beat - 1;
    end
    chk("stb_stable", stab_err, 0);
    chk("access_count", acc_addr_q.size(), exp_acc);
    for (int k = 0; k < exp_acc && k < acc_addr_q.size(); k++) begin
      chk("acc_addr", acc_addr_q[k], 16'(32'h400 | idx_e[k]));
      chk("acc_we", acc_we_q[k], we);
      chk("acc_dat", acc_dat_q[k], dat_e[k]);
    end
    if (we) for (int k = 0; k < exp_acc; k++) gold[idx_e[k]] = wbuf[k];
  endtask

  initial begin
    bus.dbg_req_valid_i  = 1'b0;
    bus.dbg_req_we_i     = 1'b0;
    bus.dbg_req_gpr_i    = '0;
    bus.dbg_req_len_i    = '0;
    bus.dbg_wdat_valid_i = 1'b0;
    bus.dbg_wdat_i       = '0;
    bus.dbg_rdat_ready_i = 1'b0;
    for (int i = 0; i < NGPR; i++) begin
      rf[i]   = $urandom;
      gold[i] = rf[i];
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.dbg_req_ready_o, 1'b1);
    chk("rst_wdat_ready", bus.dbg_wdat_ready_o, 1'b0);
    chk("rst_rvalid", bus.dbg_rdat_valid_o, 1'b0);
    chk("rst_rdat", bus.dbg_rdat_o, 32'h0);
    chk("rst_done", bus.dbg_done_o, 1'b0);
    chk("rst_err", bus.dbg_err_o, 1'b0);
    chk("rst_stb", bus.spr_bus_stb_o, 1'b0);
    chk("rst_we", bus.spr_bus_we_o, 1'b0);
    chk("rst_addr", bus.spr_bus_addr_o, 16'h0000);
    chk("rst_dat", bus.spr_bus_dat_o, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read of GPR 3, ack two cycles after stb
    rf[3] = 32'hDEADBEEF; gold[3] = 32'hDEADBEEF;
    ack_cyc = 2;
    run_txn(1'b0, 3, 0, 0, 0, 0, 1'b0);

    // Burst write wrapping from GPR 30
    for (int k = 0; k < 4; k++) wbuf[k] = DW'(k + 1);
    ack_cyc = 1;
    run_txn(1'b1, 30, 3, 0, 0, 0, 1'b0);
    chk("wrap_gpr1", rf[1], 32'd4);

    // Two-beat read with the consumer stalled for ten cycles
    run_txn(1'b0, 30, 1, 0, 10, 0, 1'b0);

    // Reset in the middle of a four-beat write, then a normal read-back
    for (int k = 0; k < 4; k++) wbuf[k] = $urandom;
    ack_cyc = 3;
    run_txn(1'b1, 8, 3, 0, 0, 2, 1'b0);
    ack_cyc = 0;
    run_txn(1'b0, 8, 3, 20, 0, 0, 1'b0);

`ifdef MOR1KX_DBG_GPR_TIMEOUT_EN
    // Never acked: abort after TMO stb-high cycles, no further access
    ack_never = 1'b1;
    run_txn(1'b0, 5, 2, 0, 0, 0, 1'b1);
    repeat (20) @(posedge clk);
    #1 chk("to_no_more_stb", stb_rises, 1);
    for (int k = 0; k < 3; k++) wbuf[k] = $urandom;
    run_txn(1'b1, 12, 2, 0, 0, 0, 1'b1);
    ack_never = 1'b0;
    // Ack in the expiry cycle completes the beat
    ack_cyc = TMO - 1;
    run_txn(1'b0, 7, 1, 0, 0, 0, 1'b0);
    chk("to_edge_stb_max", stb_max, TMO);
`else
    // Very slow ack is simply waited for
    ack_cyc = 1000;
    run_txn(1'b0, 9, 0, 0, 0, 0, 1'b0);
    chk("slow_ack_stb_max", stb_max, 1001);
`endif

    // Randomized bursts
    for (int t = 0; t < 24; t++) begin
      int len;
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 40) : $urandom_range(0, 7);
      for (int k = 0; k <= len; k++) wbuf[k] = $urandom;
      ack_cyc = $urandom_range(0, 5);
      run_txn(1'($urandom_range(0, 1)), $urandom_range(0, NGPR - 1), len,
              $urandom_range(0, 50), 0, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
